// File: rtl/tx_link_sequencer.sv
// Symbol-slot sequencer in front of the 8-bit transmitter input: electrical idle,
// TS1 training, payload forwarding with periodic SKP insertion, and an SKP drain on link-down.
//
// state     | meaning
// ELEC_IDLE | lane in electrical idle, waiting for linkEnable on a slot edge
// TRAIN     | sending TS_COUNT back-to-back TS1 ordered sets
// LINK      | forwarding payload / logical idle, inserting SKP sets
// DRAIN     | sending one closing SKP set before returning to electrical idle
module tx_link_sequencer #(
    parameter int SYM_DIV      = 10,
    parameter int TS_COUNT     = 4,
    parameter int SKP_INTERVAL = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       linkEnable,
    input  logic       payloadValid,
    input  logic [7:0] payloadData,
    output logic       payloadAck,
    output logic [7:0] txData,
    output logic       txK,
    output logic       txElecIdle,
    output logic       linkUp,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ELEC_IDLE = 2'd0,
        TRAIN     = 2'd1,
        LINK      = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    localparam int SW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam int TW = (TS_COUNT > 1) ? $clog2(TS_COUNT) : 1;
    localparam int KW = $clog2(SKP_INTERVAL + 1);

    localparam logic [SW-1:0] SLOT_LAST = SW'(SYM_DIV - 1);
    localparam logic [TW-1:0] TS_LAST   = TW'(TS_COUNT - 1);
    localparam logic [KW-1:0] SKP_DUE   = KW'(SKP_INTERVAL);

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_TS1 = 8'h4A;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_IDL = 8'h00;

    state_t        st_q, st_d;
    logic [SW-1:0] slot_q;
    logic [TW-1:0] ts_q, ts_d;
    logic [3:0]    idx_q, idx_d;
    logic [KW-1:0] skp_q, skp_d;
    logic          skp_act_q, skp_act_d;
    logic [7:0]    data_q, data_d;
    logic          k_q, k_d;
    logic          ei_q, ei_d;
    logic          ack_d;
    logic          slot_edge;

    assign slot_edge = enb && (slot_q == SLOT_LAST);

    // idx_q is the position of the symbol currently on the wire within its ordered set
    always_comb begin
        st_d      = st_q;
        ts_d      = ts_q;
        idx_d     = idx_q;
        skp_d     = skp_q;
        skp_act_d = skp_act_q;
        data_d    = data_q;
        k_d       = k_q;
        ei_d      = ei_q;
        ack_d     = 1'b0;
        if (slot_edge) begin
            case (st_q)
                ELEC_IDLE: begin
                    data_d = SYM_IDL;
                    k_d    = 1'b0;
                    ei_d   = 1'b1;
                    if (linkEnable) begin
                        st_d   = TRAIN;
                        ts_d   = '0;
                        idx_d  = '0;
                        data_d = SYM_COM;
                        k_d    = 1'b1;
                        ei_d   = 1'b0;
                    end
                end
                TRAIN: begin
                    ei_d = 1'b0;
                    if (idx_q != 4'd15) begin
                        idx_d  = idx_q + 4'd1;
                        data_d = SYM_TS1;
                        k_d    = 1'b0;
                    end else if (!linkEnable) begin
                        st_d   = ELEC_IDLE;
                        idx_d  = '0;
                        data_d = SYM_IDL;
                        k_d    = 1'b0;
                        ei_d   = 1'b1;
                    end else if (ts_q == TS_LAST) begin
                        // first LINK slot is logical idle and counts toward the SKP interval
                        st_d      = LINK;
                        idx_d     = '0;
                        skp_d     = KW'(1);
                        skp_act_d = 1'b0;
                        data_d    = SYM_IDL;
                        k_d       = 1'b0;
                    end else begin
                        ts_d   = ts_q + TW'(1);
                        idx_d  = '0;
                        data_d = SYM_COM;
                        k_d    = 1'b1;
                    end
                end
                LINK: begin
                    ei_d = 1'b0;
                    if (skp_act_q && (idx_q != 4'd3)) begin
                        idx_d  = idx_q + 4'd1;
                        data_d = SYM_SKP;
                        k_d    = 1'b1;
                    end else if (!linkEnable) begin
                        st_d      = DRAIN;
                        idx_d     = '0;
                        skp_act_d = 1'b1;
                        skp_d     = '0;
                        data_d    = SYM_COM;
                        k_d       = 1'b1;
                    end else if (skp_q == SKP_DUE) begin
                        idx_d     = '0;
                        skp_act_d = 1'b1;
                        skp_d     = '0;
                        data_d    = SYM_COM;
                        k_d       = 1'b1;
                    end else begin
                        skp_act_d = 1'b0;
                        skp_d     = skp_q + KW'(1);
                        k_d       = 1'b0;
                        if (payloadValid) begin
                            data_d = payloadData;
                            ack_d  = 1'b1;
                        end else begin
                            data_d = SYM_IDL;
                        end
                    end
                end
                DRAIN: begin
                    if (idx_q != 4'd3) begin
                        idx_d  = idx_q + 4'd1;
                        data_d = SYM_SKP;
                        k_d    = 1'b1;
                        ei_d   = 1'b0;
                    end else begin
                        st_d      = ELEC_IDLE;
                        idx_d     = '0;
                        skp_act_d = 1'b0;
                        skp_d     = '0;
                        data_d    = SYM_IDL;
                        k_d       = 1'b0;
                        ei_d      = 1'b1;
                    end
                end
                default: st_d = ELEC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= ELEC_IDLE;
            slot_q    <= '0;
            ts_q      <= '0;
            idx_q     <= '0;
            skp_q     <= '0;
            skp_act_q <= 1'b0;
            data_q    <= SYM_IDL;
            k_q       <= 1'b0;
            ei_q      <= 1'b1;
        end else if (enb) begin
            slot_q    <= slot_edge ? '0 : slot_q + SW'(1);
            st_q      <= st_d;
            ts_q      <= ts_d;
            idx_q     <= idx_d;
            skp_q     <= skp_d;
            skp_act_q <= skp_act_d;
            data_q    <= data_d;
            k_q       <= k_d;
            ei_q      <= ei_d;
        end
    end

    // ack marks the cycle whose closing edge captures payloadData
    assign payloadAck = ack_d && !rst;
    assign txData     = data_q;
    assign txK        = k_q;
    assign txElecIdle = ei_q;
    assign linkUp     = (st_q == LINK);
    assign state      = st_q;

endmodule

// File: tb/tb_tx_link_sequencer.sv
// Scoreboard bench for tx_link_sequencer: a queue-based ordered-set model predicts each
// slot's symbol and every payload ack; a negedge monitor pops and compares.
module tb_tx_link_sequencer;

    localparam int SYM_DIV      = 10;
    localparam int TS_COUNT     = 2;
    localparam int SKP_INTERVAL = 8;

    logic       clk = 1'b0;
    logic       rst, enb, linkEnable, payloadValid;
    logic [7:0] payloadData;
    logic       payloadAck;
    logic [7:0] txData;
    logic       txK, txElecIdle, linkUp;
    logic [1:0] state;

    tx_link_sequencer #(
        .SYM_DIV     (SYM_DIV),
        .TS_COUNT    (TS_COUNT),
        .SKP_INTERVAL(SKP_INTERVAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .linkEnable  (linkEnable),
        .payloadValid(payloadValid),
        .payloadData (payloadData),
        .payloadAck  (payloadAck),
        .txData      (txData),
        .txK         (txK),
        .txElecIdle  (txElecIdle),
        .linkUp      (linkUp),
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       k;
        logic       ei;
        logic [1:0] st;
    } sym_t;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } ack_t;

    sym_t sym_q[$];
    ack_t ack_q[$];

    // reference model: mode + queue of ordered-set symbols still to send ({k, byte})
    int         m_st;
    logic [8:0] m_pend[$];
    int         m_ts_left;
    int         m_skp;
    int         tb_slot;
    logic       last_ack;

    task automatic push_ts1();
        m_pend.push_back(9'h1BC);
        for (int i = 0; i < 15; i++) m_pend.push_back(9'h04A);
    endtask

    task automatic push_skp();
        m_pend.push_back(9'h1BC);
        for (int i = 0; i < 3; i++) m_pend.push_back(9'h11C);
    endtask

    task automatic model_reset();
        m_st      = 0;
        m_pend.delete();
        m_ts_left = 0;
        m_skp     = 0;
        tb_slot   = 0;
    endtask

    task automatic model_edge(input logic l, input logic v, input logic [7:0] d,
                              output logic [8:0] sym, output logic ei, output logic ack);
        sym = 9'h000;
        ei  = 1'b0;
        ack = 1'b0;
        case (m_st)
            0: begin
                if (l) begin
                    m_st = 1;
                    push_ts1();
                    m_ts_left = TS_COUNT - 1;
                    sym = m_pend.pop_front();
                end else begin
                    ei = 1'b1;
                end
            end
            1: begin
                if (m_pend.size() > 0) sym = m_pend.pop_front();
                else if (!l) begin
                    m_st = 0;
                    ei   = 1'b1;
                end else if (m_ts_left > 0) begin
                    m_ts_left--;
                    push_ts1();
                    sym = m_pend.pop_front();
                end else begin
                    m_st  = 2;
                    m_skp = 1;
                end
            end
            2: begin
                if (m_pend.size() > 0) sym = m_pend.pop_front();
                else if (!l) begin
                    m_st = 3;
                    push_skp();
                    sym = m_pend.pop_front();
                end else if (m_skp == SKP_INTERVAL) begin
                    m_skp = 0;
                    push_skp();
                    sym = m_pend.pop_front();
                end else begin
                    m_skp++;
                    if (v) begin
                        sym = {1'b0, d};
                        ack = 1'b1;
                    end
                end
            end
            default: begin
                if (m_pend.size() > 0) sym = m_pend.pop_front();
                else begin
                    m_st = 0;
                    ei   = 1'b1;
                end
            end
        endcase
    endtask

    // drive one clock's inputs, record predictions for it, advance to posedge+2
    task automatic step(input logic r, input logic e, input logic l, input logic v,
                        input logic [7:0] d);
        logic [8:0] sym;
        logic       ei, ack;
        sym_t       s;
        ack_t       a;
        rst = r; enb = e; linkEnable = l; payloadValid = v; payloadData = d;
        last_ack = 1'b0;
        if (r) begin
            model_reset();
            s.cyc = cyc + 1; s.d = 8'h00; s.k = 1'b0; s.ei = 1'b1; s.st = 2'd0;
            sym_q.push_back(s);
        end else if (e) begin
            if (tb_slot == SYM_DIV - 1) begin
                tb_slot = 0;
                model_edge(l, v, d, sym, ei, ack);
                s.cyc = cyc + 1; s.d = sym[7:0]; s.k = sym[8]; s.ei = ei; s.st = 2'(m_st);
                sym_q.push_back(s);
                if (ack) begin
                    a.cyc = cyc; a.d = d;
                    ack_q.push_back(a);
                    last_ack = 1'b1;
                end
            end else begin
                tb_slot++;
            end
        end
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        ack_t a;
        sym_t s;
        if (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            a = ack_q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL missed_ack cyc=%0d actual=0 required=1 byte=%02h", a.cyc, a.d);
        end
        if (payloadAck === 1'b1) begin
            n_cmp++;
            if (ack_q.size() == 0 || ack_q[0].cyc != cyc) begin
                n_bad++;
                $display("FAIL spurious_ack cyc=%0d actual=1 required=0", cyc);
            end else begin
                a = ack_q.pop_front();
                if (payloadData !== a.d) begin
                    n_bad++;
                    $display("FAIL ack_byte cyc=%0d actual=%02h required=%02h", cyc, payloadData, a.d);
                end
            end
        end
        while (sym_q.size() > 0 && sym_q[0].cyc <= cyc) begin
            s = sym_q.pop_front();
            n_cmp++;
            if (s.cyc != cyc || txData !== s.d || txK !== s.k || txElecIdle !== s.ei ||
                state !== s.st || linkUp !== (s.st == 2'd2)) begin
                n_bad++;
                $display("FAIL symbol cyc=%0d actual d=%02h k=%0b ei=%0b st=%0d up=%0b required d=%02h k=%0b ei=%0b st=%0d",
                         s.cyc, txData, txK, txElecIdle, state, linkUp, s.d, s.k, s.ei, s.st);
            end
        end
    end

    task automatic timeout(input string what);
        n_cmp++; n_bad++;
        $display("FAIL timeout_%s actual=expired required=reached", what);
    endtask

    initial begin
        logic [7:0] up_byte;
        logic       le, r, e, v;
        int         guard;
        rst = 1'b1; enb = 1'b1; linkEnable = 1'b0; payloadValid = 1'b0; payloadData = 8'h00;
        last_ack = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // bring-up with no payload: TS1 x2, 8 idles, first SKP
        repeat (480) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

        // continuous payload stream 11, 22, ...
        up_byte = 8'h11;
        repeat (250) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, up_byte);
            if (last_ack) up_byte = up_byte + 8'h11;
        end

        // payload appears exactly when an SKP is due
        guard = 0;
        while (!(m_st == 2 && m_pend.size() == 0 && m_skp == SKP_INTERVAL) && guard < 400) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5);
            guard++;
        end
        if (guard >= 400) timeout("skp_due");
        guard = 0;
        do begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5);
            guard++;
        end while (!last_ack && guard < 200);
        if (guard >= 200) timeout("a5_ack");

        // link down in the middle of an SKP set, payload still offered
        guard = 0;
        while (!(m_st == 2 && m_pend.size() == 2) && guard < 300) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, up_byte);
            if (last_ack) up_byte = up_byte + 8'h11;
            guard++;
        end
        if (guard >= 300) timeout("mid_skp");
        repeat (120) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, up_byte);
            if (last_ack) up_byte = up_byte + 8'h11;
        end

        // enable freeze in the middle of a TS1
        guard = 0;
        while (!(m_st == 1 && m_pend.size() == 8) && guard < 300) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
            guard++;
        end
        if (guard >= 300) timeout("mid_ts1");
        repeat (25) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
        repeat (400) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);

        // reset in the middle of payload
        repeat (153) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, up_byte);
            if (last_ack) up_byte = up_byte + 8'h11;
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, up_byte);
        step(1'b1, 1'b0, 1'b1, 1'b1, up_byte);

        // randomized traffic
        le = 1'b1;
        up_byte = 8'($urandom_range(0, 255));
        repeat (4000) begin
            r = ($urandom_range(0, 999) == 0);
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 399) == 0) le = ~le;
            v = ($urandom_range(0, 9) < 7);
            step(r, e, le, v, up_byte);
            if (last_ack) up_byte = 8'($urandom_range(0, 255));
        end
        repeat (5) step(1'b0, 1'b1, le, 1'b0, 8'h00);

        @(negedge clk);
        #1;
        n_cmp++;
        if (sym_q.size() != 0 || ack_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expectations actual=%0d required=0", sym_q.size() + ack_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
